ctrl_sequencer: RTL and testbench
=================================

# ctrl_sequencer

Parametrised instruction control sequencer for the CPU. It steps each instruction through three phases: FETCH, NEXT (PC increment) and EXEC, with a one-hot step vector per phase, and decodes the latched opcode to a one-hot execute strobe. Unlike the fixed five-stage sequencers, it supports a per-instruction execute length, conditional skip of EXEC, single-step mode and a retired-instruction counter. Datapath control words are derived outside this block from `phase`, `step` and `op_onehot`.

## Interface
Parameters:
- OPC_W, 3, opcode width; `op_onehot` is 2^OPC_W wide.
- STEPS, 5, steps in FETCH and NEXT, and the maximum EXEC length (≥2).
- COND_MASK, 8'b0100_0000, bit i set means opcode i executes only if `cond`=1 (width 2^OPC_W).
- CNT_W, 16, width of the retired-instruction counter.
- LEN_W is derived as $clog2(STEPS+1).

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- start  in  1  power-on start request, honoured only in IDLE.
- run  in  1  status/enable; gates instruction issue from WAIT.
- step_mode  in  1  1 = issue one instruction per `step_req`.
- step_req  in  1  level; sampled in WAIT when `step_mode`=1.
- opcode  in  OPC_W  instruction opcode (IR field).
- exec_len  in  LEN_W  EXEC step count for `opcode`.
- cond  in  1  branch/condition flag (e.g. carry).
- phase  out  3  IDLE=0, WAIT=1, FETCH=2, NEXT=3, EXEC=4.
- step  out  STEPS  one-hot step within FETCH/NEXT/EXEC; zero in IDLE and WAIT.
- op_onehot  out  2^OPC_W  decoded latched opcode; nonzero only in EXEC.
- fetch_start  out  1  high on FETCH step[0].
- op_start  out  1  high on EXEC step[0].
- instr_done  out  1  one-cycle pulse at instruction retirement.
- skipped  out  1  one-cycle pulse when EXEC was skipped.
- running  out  1  high in every phase except IDLE.
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.

## Operation
- Reset: phase=IDLE, step=0, op_onehot=0, all pulses 0, running=0, instr_count=0, internal opcode/length registers 0.
- IDLE: `start`=1 moves to WAIT on the next edge. Otherwise remain in IDLE.
- WAIT: issue when `run` & (~`step_mode` | `step_req`), moving to FETCH step[0]. Otherwise hold.
- FETCH: advance step[0]..step[STEPS-1], then NEXT step[0].
- NEXT: advance step[0]..step[STEPS-1]. On the last NEXT cycle, sample `opcode`, `exec_len` and `cond`:
  - Effective length L = 1 if exec_len=0; STEPS if exec_len>STEPS; otherwise exec_len.
  - If COND_MASK[opcode]=1 and cond=0: go to WAIT. `skipped` and `instr_done` pulse in that first WAIT cycle.
  - Otherwise go to EXEC step[0].
- EXEC: step[0]..step[L-1], with op_onehot = 1<<opcode_latched throughout. Then go to WAIT, with `instr_done` pulsing in the first WAIT cycle.
- instr_count increments by 1 on every `instr_done`, including skipped instructions.
- `run` or `step_mode` changes mid-instruction have no effect until WAIT; the instruction always completes.
- `start` outside IDLE is ignored. Opcode, cond and len changes outside the last NEXT cycle are ignored.
- `reset` at any cycle forces IDLE state on the next edge. No pulse is emitted.
- In step mode, one instruction issues per WAIT cycle in which `step_req`=1. Holding `step_req` high issues back-to-back instructions.

## Timing
- All outputs are registered or decoded from registered state only; there are no combinational input-to-output paths.
- `start` to FETCH: 2 cycles (IDLE→WAIT→FETCH) with `run`=1.
- Instruction period at full rate: 2·STEPS + L + 1 cycles (defaults with L=5: 16).
- Skipped instruction period: 2·STEPS + 1 cycles (defaults: 11).
- `instr_done` to the next `fetch_start`: 1 cycle minimum (the one WAIT cycle).
- `instr_count` updates on the edge ending the `instr_done` cycle.

## Test plan
- Reset, then hold idle: all outputs 0, phase=0 for 10 cycles; `start` with `reset`=1 stays in IDLE.
- `start` pulse, run=1, opcode=0, exec_len=5:
  - phase sequence 0,1, then 2×5, 3×5, 4×5, then 1.
  - op_onehot=8'h01 only in EXEC.
  - instr_done in cycle 18, instr_count=1.
  - Next fetch_start 16 cycles after the previous one.
- opcode=6, cond=0: no EXEC, skipped=instr_done=1 for one cycle, period 11. With cond=1: EXEC with op_onehot=8'h40, period 16.
- exec_len=0: EXEC lasts 1 cycle (step=5'b00001). exec_len=7: EXEC lasts 5 cycles.
- step_mode and run control:
  - step_mode=1, step_req=0: stays in WAIT indefinitely.
  - A one-cycle step_req: exactly one instruction, then back to WAIT.
  - run dropped at EXEC step[1]: the instruction completes, instr_done pulses, then the block holds in WAIT.
- Reset and counter wrap:
  - reset asserted at EXEC step[2]: phase=IDLE and instr_count=0 the next cycle, no instr_done.
  - With CNT_W=4: 16 retired instructions return instr_count to 0.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: steps each instruction through FETCH, NEXT and EXEC with a
// one-hot step vector, variable EXEC length, conditional skip and retire count.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             leave IDLE (ignored elsewhere)
//   run, step_mode,   issue gating, sampled only in WAIT
//   step_req
//   opcode, exec_len, instruction fields, sampled on the last NEXT step
//   cond
//   phase             IDLE=0 WAIT=1 FETCH=2 NEXT=3 EXEC=4
//   step              one-hot step inside FETCH/NEXT/EXEC
//   op_onehot         decoded latched opcode, EXEC only
//   fetch_start       first FETCH step
//   op_start          first EXEC step
//   instr_done        retirement pulse (first WAIT cycle after an instruction)
//   skipped           EXEC was skipped for the retiring instruction
//   running           not IDLE
//   instr_count       retired instructions, wrapping
module ctrl_sequencer #(
    parameter int                  OPC_W     = 3,
    parameter int                  STEPS     = 5,
    parameter logic [2**OPC_W-1:0] COND_MASK = 8'b0100_0000,
    parameter int                  CNT_W     = 16,
    localparam int                 LEN_W     = $clog2(STEPS + 1),
    localparam int                 OPS       = 2**OPC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic [OPC_W-1:0] opcode,
    input  logic [LEN_W-1:0] exec_len,
    input  logic             cond,
    output logic [2:0]       phase,
    output logic [STEPS-1:0] step,
    output logic [OPS-1:0]   op_onehot,
    output logic             fetch_start,
    output logic             op_start,
    output logic             instr_done,
    output logic             skipped,
    output logic             running,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        P_IDLE  = 3'd0,
        P_WAIT  = 3'd1,
        P_FETCH = 3'd2,
        P_NEXT  = 3'd3,
        P_EXEC  = 3'd4
    } phase_t;

    localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LAST = LEN_W'(STEPS - 1);
    localparam logic [LEN_W-1:0] MAXL = LEN_W'(STEPS);

    phase_t           phase_q, phase_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [OPC_W-1:0] op_q, op_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             done_q, done_d;
    logic             skip_q, skip_d;
    logic [CNT_W-1:0] cnt_q;

    logic             issue;
    logic             cond_block;
    logic [LEN_W-1:0] len_eff;

    assign issue      = run & (~step_mode | step_req);
    assign cond_block = COND_MASK[opcode] & ~cond;

    // Zero-length means a single EXEC step; oversize clamps to STEPS.
    always_comb begin
        if (exec_len == '0) begin
            len_eff = ONE;
        end else if (exec_len > MAXL) begin
            len_eff = MAXL;
        end else begin
            len_eff = exec_len;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= P_IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            skip_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            len_q   <= len_d;
            done_q  <= done_d;
            skip_q  <= skip_d;
            if (done_q) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        phase_d = phase_q;
        idx_d   = idx_q;
        op_d    = op_q;
        len_d   = len_q;
        done_d  = 1'b0;
        skip_d  = 1'b0;
        unique case (phase_q)
            P_IDLE: begin
                if (start) begin
                    phase_d = P_WAIT;
                end
            end
            P_WAIT: begin
                if (issue) begin
                    phase_d = P_FETCH;
                    idx_d   = '0;
                end
            end
            P_FETCH: begin
                if (idx_q == LAST) begin
                    phase_d = P_NEXT;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ONE;
                end
            end
            P_NEXT: begin
                if (idx_q == LAST) begin
                    op_d  = opcode;
                    len_d = len_eff;
                    idx_d = '0;
                    if (cond_block) begin
                        phase_d = P_WAIT;
                        done_d  = 1'b1;
                        skip_d  = 1'b1;
                    end else begin
                        phase_d = P_EXEC;
                    end
                end else begin
                    idx_d = idx_q + ONE;
                end
            end
            P_EXEC: begin
                if (idx_q == len_q - ONE) begin
                    phase_d = P_WAIT;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + ONE;
                end
            end
            default: begin
                phase_d = P_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        step        = '0;
        op_onehot   = '0;
        fetch_start = 1'b0;
        op_start    = 1'b0;
        unique case (phase_q)
            P_FETCH: begin
                step        = STEPS'(1) << idx_q;
                fetch_start = (idx_q == '0);
            end
            P_NEXT: begin
                step = STEPS'(1) << idx_q;
            end
            P_EXEC: begin
                step      = STEPS'(1) << idx_q;
                op_onehot = OPS'(1) << op_q;
                op_start  = (idx_q == '0);
            end
            default: begin
            end
        endcase
    end

    assign phase       = phase_q;
    assign running     = (phase_q != P_IDLE);
    assign instr_done  = done_q;
    assign skipped     = skip_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: randomized scoreboard bench for ctrl_sequencer.
// Expected event times come from instruction-period arithmetic.
module tb_ctrl_sequencer;
  localparam int S = 5;
  localparam int CW = 4;
  localparam logic [7:0] MASK = 8'b0100_0000;

  logic clk = 1'b0;
  logic reset, start, run, step_mode, step_req, cond;
  logic [2:0] opcode;
  logic [2:0] exec_len;
  logic [2:0] phase;
  logic [S-1:0] step;
  logic [7:0] op_onehot;
  logic fetch_start, op_start, instr_done, skipped, running;
  logic [CW-1:0] instr_count;

  ctrl_sequencer #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .run(run),
    .step_mode(step_mode), .step_req(step_req),
    .opcode(opcode), .exec_len(exec_len), .cond(cond),
    .phase(phase), .step(step), .op_onehot(op_onehot),
    .fetch_start(fetch_start), .op_start(op_start),
    .instr_done(instr_done), .skipped(skipped),
    .running(running), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int cyc;
    int oh;
    int len;
    int skp;
    int cnt;
  } rec_t;

  int   fetch_q[$];
  rec_t exec_q[$];
  rec_t done_q[$];

  int ek = 0;
  int cur_oh = 0;

  always @(negedge clk) begin
    rec_t r;
    int f;
    if (fetch_start) begin
      if (fetch_q.size() == 0) begin
        chk("fetch_unexpected", int'(fetch_start), 0);
      end else begin
        f = fetch_q.pop_front();
        chk("fetch_cycle", cyc, f);
        chk("fetch_step", int'(step), 1);
      end
    end
    if (op_start) begin
      if (exec_q.size() == 0) begin
        chk("exec_unexpected", int'(op_start), 0);
      end else begin
        r = exec_q.pop_front();
        chk("exec_cycle", cyc, r.cyc);
        cur_oh = r.oh;
        ek = 0;
      end
    end
    if (phase == 3'd4) begin
      chk("exec_onehot", int'(op_onehot), cur_oh);
      chk("exec_step", int'(step), 1 << ek);
      ek++;
    end else begin
      chk("onehot_outside_exec", int'(op_onehot), 0);
    end
    if (instr_done) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", int'(instr_done), 0);
      end else begin
        r = done_q.pop_front();
        chk("done_cycle", cyc, r.cyc);
        chk("skipped", int'(skipped), r.skp);
        chk("instr_count", int'(instr_count), r.cnt);
        if (r.skp == 0) chk("exec_len", ek, r.len);
      end
    end else begin
      chk("skip_without_done", int'(skipped), 0);
    end
  end

  int w;
  int model_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic garbage();
    opcode   = 3'($urandom);
    exec_len = 3'($urandom);
    cond     = 1'($urandom);
  endtask

  // Issue one instruction from the WAIT cycle w, after idle_n stalled cycles.
  task automatic run_instr(input int op, input int len, input int cnd,
                           input int idle_n, input bit rst_mid);
    int leff;
    int skp;
    int issue;
    int es;
    int done_c;
    rec_t r;
    leff   = (len == 0) ? 1 : (len > S) ? S : len;
    skp    = (MASK[op] && cnd == 0) ? 1 : 0;
    issue  = w + idle_n;
    es     = issue + 1 + 2 * S;
    done_c = (skp != 0) ? es : es + leff;
    for (int k = 0; k < idle_n; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        run = 1'b1; step_mode = 1'b1;
      end else begin
        run = 1'b0; step_mode = 1'($urandom);
      end
      step_req = 1'b0;
      start    = 1'($urandom);
      garbage();
      chk("wait_phase", int'(phase), 1);
      chk("wait_step", int'(step), 0);
      tick();
    end
    run       = 1'b1;
    step_mode = 1'($urandom);
    step_req  = step_mode ? 1'b1 : 1'($urandom);
    start     = 1'($urandom);
    garbage();
    chk("issue_phase", int'(phase), 1);
    chk("issue_running", int'(running), 1);
    fetch_q.push_back(issue + 1);
    if (skp == 0) begin
      r.cyc = es; r.oh = 1 << op; r.len = leff; r.skp = 0; r.cnt = 0;
      exec_q.push_back(r);
    end
    if (!rst_mid) begin
      r.cyc = done_c; r.oh = 0; r.len = leff; r.skp = skp;
      r.cnt = model_cnt;
      done_q.push_back(r);
    end
    tick();
    while (cyc < done_c) begin
      run       = 1'($urandom);
      step_mode = 1'($urandom);
      step_req  = 1'($urandom);
      start     = 1'($urandom);
      garbage();
      if (cyc == es - 1) begin
        opcode   = 3'(op);
        exec_len = 3'(len);
        cond     = 1'(cnd);
      end
      if (rst_mid && cyc == es + 2) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("reset_phase", int'(phase), 0);
        chk("reset_count", int'(instr_count), 0);
        chk("reset_no_done", int'(instr_done), 0);
        chk("reset_running", int'(running), 0);
        start = 1'b1; run = 1'b1; step_mode = 1'b0;
        tick();
        start = 1'b0;
        w = cyc;
        model_cnt = 0;
        return;
      end
      tick();
    end
    model_cnt = (model_cnt + 1) % (1 << CW);
    w = done_c;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; run = 1'b0;
    step_mode = 1'b0; step_req = 1'b0;
    garbage();
    model_cnt = 0;
    tick();
    tick();
    chk("rst_phase", int'(phase), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_onehot", int'(op_onehot), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_count", int'(instr_count), 0);
    chk("rst_done", int'(instr_done), 0);
    reset = 1'b0;
    repeat (10) begin
      tick();
      chk("idle_phase", int'(phase), 0);
      chk("idle_running", int'(running), 0);
      chk("idle_step", int'(step), 0);
    end
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("start_in_reset", int'(phase), 0);
    start = 1'b1; run = 1'b1;
    tick();
    start = 1'b0;
    w = cyc;
    run_instr(0, 5, 0, 0, 1'b0);
    run_instr(0, 5, 1, 0, 1'b0);
    run_instr(6, 5, 0, 0, 1'b0);
    run_instr(6, 5, 1, 0, 1'b0);
    run_instr(3, 0, 1, 0, 1'b0);
    run_instr(2, 7, 0, 0, 1'b0);
    run_instr(5, 3, 1, 6, 1'b0);
    run_instr(1, 4, 1, 0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      run_instr($urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 1),
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                1'b0);
    end
    run = 1'b0;
    tick();
    tick();
    chk("final_count", int'(instr_count), model_cnt);
    chk("final_wait", int'(phase), 1);
    chk("fetch_left", fetch_q.size(), 0);
    chk("exec_left", exec_q.size(), 0);
    chk("done_left", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
